// File: rtl/analog_seq_pkg.sv
// Shared types and constants for the analog frame sequencer.
// Optional macro: ANALOG_SEQ_SYNC_EN selects a 2-flop synchroniser on the phase inputs.
// No ports; imported by the sequencer and its phase edge detector.
package analog_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LINE  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

`ifdef ANALOG_SEQ_SYNC_EN
  localparam int unsigned SYNC_STAGES = 2;
`else
  localparam int unsigned SYNC_STAGES = 0;
`endif

endpackage

// File: rtl/analog_frame_sequencer_if.sv
// Bus bundle between sequencer control software/ADC capture and the sequencer.
// master: drives enable, phase inputs and configuration; receives status and strobes.
// slave : the sequencer side.
interface analog_frame_sequencer_if #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LINE_W = 10
);

  logic              i_enable;
  logic              i_phi_l2;
  logic              i_phi_p;
  logic [CNT_W-1:0]  i_pixel_idx;
  logic [CNT_W-1:0]  i_pixels_per_line;
  logic [LINE_W-1:0] i_lines_per_frame;

  logic              o_ADC_frame;
  logic              o_pixel_flag;
  logic [CNT_W-1:0]  o_line_len;
  logic              o_line_ok;
  logic              o_line_done;
  logic              o_frame_done;
  logic              o_overflow;

  modport master (
    output i_enable, i_phi_l2, i_phi_p, i_pixel_idx, i_pixels_per_line, i_lines_per_frame,
    input  o_ADC_frame, o_pixel_flag, o_line_len, o_line_ok, o_line_done, o_frame_done,
           o_overflow
  );

  modport slave (
    input  i_enable, i_phi_l2, i_phi_p, i_pixel_idx, i_pixels_per_line, i_lines_per_frame,
    output o_ADC_frame, o_pixel_flag, o_line_len, o_line_ok, o_line_done, o_frame_done,
           o_overflow
  );

endinterface

// File: rtl/phase_edge_detect.sv
// Optional synchroniser followed by a registered sample and a 0->1 edge detector.
// Depth is SYNC_STAGES+1 flops, so the rising-edge event appears SYNC_STAGES+1 clocks
// after the phase is first sampled high (ANALOG_SEQ_SYNC_EN adds the synchroniser).
// Ports: clk, rst (sync active-high), phase (raw phase input), rise_c (one-cycle event).
module phase_edge_detect
  import analog_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic phase,
  output logic rise_c
);

  localparam int unsigned DEPTH = SYNC_STAGES + 1;

  logic [DEPTH-1:0] chain;
  logic             prev;

  // Shift chain; the MSB is the sampled, synchronised phase level
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= DEPTH'({chain, phase});
      prev  <= chain[DEPTH-1];
    end
  end

  assign rise_c = chain[DEPTH-1] & ~prev;

endmodule

// File: rtl/analog_frame_sequencer.sv
// Frames multi-line acquisitions from the phi_p / phi_l2 phase inputs and drives
// the ADC frame gate, pixel strobe and line status.
// Optional macro: ANALOG_SEQ_SYNC_EN (2-flop synchronisers on both phases, latency 3).
// Ports: i_clk, i_rst (sync active-high), bus (slave modport: enable, phases,
//        pixel index / line length / frame length config; frame, flag, line status,
//        done pulses, overflow).
module analog_frame_sequencer
  import analog_seq_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LINE_W = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  analog_frame_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] PIX_MAX = '1;

  logic p_rise_c;
  logic l2_rise_c;

  phase_edge_detect u_p_edge (
    .clk    (i_clk),
    .rst    (i_rst),
    .phase  (bus.i_phi_p),
    .rise_c (p_rise_c)
  );

  phase_edge_detect u_l2_edge (
    .clk    (i_clk),
    .rst    (i_rst),
    .phase  (bus.i_phi_l2),
    .rise_c (l2_rise_c)
  );

  seq_state_e        state, state_n;
  logic [CNT_W-1:0]  pix_cnt, pix_cnt_n;
  logic [LINE_W-1:0] line_cnt, line_cnt_n;
  logic              frame, frame_n;
  logic              pixel_flag, pixel_flag_n;
  logic [CNT_W-1:0]  line_len, line_len_n;
  logic              line_ok, line_ok_n;
  logic              line_done, line_done_n;
  logic              frame_done, frame_done_n;
  logic              overflow, overflow_n;

  logic [CNT_W-1:0]  pix_inc_c;
  logic [LINE_W-1:0] line_inc_c;

  assign pix_inc_c  = pix_cnt + CNT_W'(1);
  assign line_inc_c = line_cnt + LINE_W'(1);

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      frame      <= 1'b0;
      pixel_flag <= 1'b0;
      line_len   <= '0;
      line_ok    <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      pix_cnt    <= pix_cnt_n;
      line_cnt   <= line_cnt_n;
      frame      <= frame_n;
      pixel_flag <= pixel_flag_n;
      line_len   <= line_len_n;
      line_ok    <= line_ok_n;
      line_done  <= line_done_n;
      frame_done <= frame_done_n;
      overflow   <= overflow_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    pix_cnt_n    = pix_cnt;
    line_cnt_n   = line_cnt;
    frame_n      = frame;
    line_len_n   = line_len;
    line_ok_n    = line_ok;
    overflow_n   = overflow;
    pixel_flag_n = 1'b0;
    line_done_n  = 1'b0;
    frame_done_n = 1'b0;

    unique case (state)
      IDLE: begin
        pix_cnt_n  = '0;
        line_cnt_n = '0;
        frame_n    = 1'b0;
        if (bus.i_enable) state_n = ARMED;
      end

      ARMED: begin
        if (p_rise_c) begin
          state_n    = LINE;
          pix_cnt_n  = '0;
          line_cnt_n = '0;
          frame_n    = 1'b1;
        end
      end

      LINE: begin
        // p_rise has priority: a coincident l2 edge is dropped
        if (p_rise_c) begin
          line_len_n  = pix_cnt;
          line_ok_n   = (pix_cnt == bus.i_pixels_per_line) && !overflow;
          line_done_n = 1'b1;
          line_cnt_n  = line_inc_c;
          pix_cnt_n   = '0;
          overflow_n  = 1'b0;
          if ((bus.i_lines_per_frame != '0) && (line_inc_c == bus.i_lines_per_frame)) begin
            state_n      = DONE;
            frame_n      = 1'b0;
            frame_done_n = 1'b1;
          end
        end else if (l2_rise_c) begin
          if (pix_cnt == PIX_MAX) begin
            overflow_n = 1'b1;
          end else begin
            pix_cnt_n = pix_inc_c;
            if ((bus.i_pixel_idx != '0) && (pix_inc_c == bus.i_pixel_idx)) begin
              pixel_flag_n = 1'b1;
            end
          end
        end
      end

      DONE: begin
        state_n = ARMED;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Disable aborts everything without done pulses; line status holds
    if (!bus.i_enable) begin
      state_n      = IDLE;
      pix_cnt_n    = '0;
      line_cnt_n   = '0;
      frame_n      = 1'b0;
      overflow_n   = 1'b0;
      pixel_flag_n = 1'b0;
      line_done_n  = 1'b0;
      frame_done_n = 1'b0;
    end
  end

  assign bus.o_ADC_frame  = frame;
  assign bus.o_pixel_flag = pixel_flag;
  assign bus.o_line_len   = line_len;
  assign bus.o_line_ok    = line_ok;
  assign bus.o_line_done  = line_done;
  assign bus.o_frame_done = frame_done;
  assign bus.o_overflow   = overflow;

endmodule
